// File: rtl/fifo_input_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle for fifo_input_arbiter.
// The master modport is the arbiter; the slave modport is the producers plus the FIFO.
interface fifo_input_arbiter_if #(
  parameter int DATABITWIDTH = 16,
  parameter int PORTCOUNT    = 4
);
  localparam int IDBITWIDTH = $clog2(PORTCOUNT);

  logic [PORTCOUNT-1:0]              ReqIn;
  logic [PORTCOUNT-1:0]              AckOut;
  logic [PORTCOUNT*DATABITWIDTH-1:0] DataIn;
  logic                              FifoREQ;
  logic                              FifoACK;
  logic [DATABITWIDTH-1:0]           FifoData;
  logic [IDBITWIDTH-1:0]             GrantID;
  logic                              Busy;

  modport master (
    input  ReqIn, DataIn, FifoACK,
    output AckOut, FifoREQ, FifoData, GrantID, Busy
  );

  modport slave (
    output ReqIn, DataIn, FifoACK,
    input  AckOut, FifoREQ, FifoData, GrantID, Busy
  );
endinterface

// File: rtl/fifo_input_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO input port between producers.
// A grant lasts up to BURSTLIMIT words; every release is followed by one IDLE cycle.
module fifo_input_arbiter #(
  parameter int DATABITWIDTH = 16,
  parameter int PORTCOUNT    = 4,
  parameter int BURSTLIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  fifo_input_arbiter_if.master  bus
);
  localparam int IDBITWIDTH = $clog2(PORTCOUNT);
  localparam int BCW        = $clog2(BURSTLIMIT + 1);
  localparam logic [IDBITWIDTH-1:0] LAST_ID = IDBITWIDTH'(PORTCOUNT - 1);
  localparam logic [BCW-1:0]        LIMIT   = BCW'(BURSTLIMIT);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e                state_q, state_d;
  logic [IDBITWIDTH-1:0] ptr_q, ptr_d;
  logic [IDBITWIDTH-1:0] gid_q, gid_d;
  logic [BCW-1:0]        burst_q, burst_d;

  logic                    win_found;
  logic [IDBITWIDTH-1:0]   win_id;
  logic                    req_g;
  logic                    xfer;
  logic [BCW-1:0]          burst_inc;
  logic [PORTCOUNT-1:0]    ack_o;
  logic                    freq_o;
  logic [DATABITWIDTH-1:0] data_o;
  logic                    busy_o;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      burst_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      burst_q <= burst_d;
    end
  end

  // First requesting port at or after the pointer, wrapping modulo PORTCOUNT.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < PORTCOUNT; k++) begin
      if (!win_found && bus.ReqIn[(int'(ptr_q) + k) % PORTCOUNT]) begin
        win_found = 1'b1;
        win_id    = IDBITWIDTH'((int'(ptr_q) + k) % PORTCOUNT);
      end
    end
  end

  assign req_g     = bus.ReqIn[gid_q];
  assign burst_inc = burst_q + BCW'(1);
  assign xfer      = (state_q == GRANTED) && clk_en && req_g && bus.FifoACK;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    burst_d = burst_q;
    ack_o   = '0;
    freq_o  = 1'b0;
    data_o  = '0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clk_en && win_found) begin
          gid_d   = win_id;
          burst_d = '0;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        busy_o       = 1'b1;
        freq_o       = clk_en & req_g;
        data_o       = bus.DataIn[gid_q*DATABITWIDTH +: DATABITWIDTH];
        ack_o[gid_q] = clk_en & bus.FifoACK;
        if (xfer) begin
          burst_d = burst_inc;
        end
        // Release on a full burst or when the granted producer withdraws.
        if ((xfer && burst_inc == LIMIT) || (clk_en && !req_g)) begin
          state_d = IDLE;
          ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + IDBITWIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.AckOut   = ack_o;
  assign bus.FifoREQ  = freq_o;
  assign bus.FifoData = data_o;
  assign bus.GrantID  = gid_q;
  assign bus.Busy     = busy_o;
endmodule

// File: tb/tb_fifo_input_arbiter.sv
// Directed bench for fifo_input_arbiter: a vector table for full contention plus
// hand-written sequences for single producer, backpressure, enable, withdrawal and reset.
module tb_fifo_input_arbiter;
  localparam int DW = 16;
  localparam int PC = 4;

  logic clk = 1'b0;
  logic clk_en;
  logic sync_rst;

  fifo_input_arbiter_if #(.DATABITWIDTH(DW), .PORTCOUNT(PC)) bus ();

  fifo_input_arbiter #(.DATABITWIDTH(DW), .PORTCOUNT(PC), .BURSTLIMIT(4)) dut (
    .clk      (clk),
    .clk_en   (clk_en),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic        ack;
    logic        e_freq;
    logic [3:0]  e_ack;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic en, logic [3:0] req, logic ack, logic e_freq,
                              logic [3:0] e_ack, logic [1:0] e_gid, logic e_busy,
                              logic [15:0] e_data);
    vec_t v;
    v.en = en; v.req = req; v.ack = ack; v.e_freq = e_freq; v.e_ack = e_ack;
    v.e_gid = e_gid; v.e_busy = e_busy; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    sync_rst = 1'b1; clk_en = 1'b0; bus.ReqIn = '0; bus.FifoACK = 1'b0;
    cyc();
    sync_rst = 1'b0;
  endtask

  task automatic set_base_data();
    for (int i = 0; i < PC; i++) bus.DataIn[i*DW +: DW] = 16'hD000 + 16'(i);
  endtask

  logic [15:0] words [3];

  initial begin
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
    set_base_data();

    // Full contention, BURSTLIMIT=4: grant order 0,1,2,3,0 with one idle bubble each.
    for (int g = 0; g < PC; g++) begin
      tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b0, 4'b0000, (g == 0) ? 2'd0 : 2'(g - 1), 1'b0, 16'h0));
      for (int w = 0; w < 4; w++)
        tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b1, 4'(1 << g), 2'(g), 1'b1, 16'hD000 + 16'(g)));
    end
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 16'h0));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 16'hD000));

    // Reset state
    sync_rst = 1'b1; clk_en = 1'b0; bus.ReqIn = '0; bus.FifoACK = 1'b0;
    cyc(); cyc();
    #2;
    chk("rst_freq", 32'(bus.FifoREQ), 32'd0);
    chk("rst_ack",  32'(bus.AckOut), 32'd0);
    chk("rst_data", 32'(bus.FifoData), 32'd0);
    chk("rst_gid",  32'(bus.GrantID), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    cyc();
    sync_rst = 1'b0;

    foreach (tbl[i]) begin
      clk_en = tbl[i].en; bus.ReqIn = tbl[i].req; bus.FifoACK = tbl[i].ack;
      #2;
      chk($sformatf("tbl%0d_freq", i), 32'(bus.FifoREQ), 32'(tbl[i].e_freq));
      chk($sformatf("tbl%0d_ack", i),  32'(bus.AckOut), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_gid", i),  32'(bus.GrantID), 32'(tbl[i].e_gid));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.Busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_data", i), 32'(bus.FifoData), 32'(tbl[i].e_data));
      cyc();
    end

    // Single producer: port 2 sends three words
    reset_dut();
    bus.DataIn[2*DW +: DW] = words[0];
    clk_en = 1'b1; bus.ReqIn = 4'b0100; bus.FifoACK = 1'b1;
    #2;
    chk("sp_idle_busy", 32'(bus.Busy), 32'd0);
    chk("sp_idle_ack", 32'(bus.AckOut), 32'd0);
    cyc();
    for (int w = 0; w < 3; w++) begin
      bus.DataIn[2*DW +: DW] = words[w];
      #2;
      chk($sformatf("sp_gid%0d", w), 32'(bus.GrantID), 32'd2);
      chk($sformatf("sp_ack%0d", w), 32'(bus.AckOut), 32'b0100);
      chk($sformatf("sp_data%0d", w), 32'(bus.FifoData), 32'(words[w]));
      chk($sformatf("sp_freq%0d", w), 32'(bus.FifoREQ), 32'd1);
      cyc();
    end
    bus.ReqIn = 4'b0000;
    #2;
    chk("sp_wd_freq", 32'(bus.FifoREQ), 32'd0);
    chk("sp_wd_busy", 32'(bus.Busy), 32'd1);
    chk("sp_burst3", 32'(dut.burst_q), 32'd3);
    cyc();
    #2;
    chk("sp_rel_busy", 32'(bus.Busy), 32'd0);
    chk("sp_ptr", 32'(dut.ptr_q), 32'd3);
    set_base_data();

    // Backpressure during a grant to port 1
    reset_dut();
    clk_en = 1'b1; bus.ReqIn = 4'b0010; bus.FifoACK = 1'b1;
    cyc();
    cyc();
    bus.FifoACK = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("bp_freq%0d", c), 32'(bus.FifoREQ), 32'd1);
      chk($sformatf("bp_ack%0d", c), 32'(bus.AckOut), 32'd0);
      chk($sformatf("bp_gid%0d", c), 32'(bus.GrantID), 32'd1);
      chk($sformatf("bp_burst%0d", c), 32'(dut.burst_q), 32'd1);
      cyc();
    end
    bus.FifoACK = 1'b1;
    #2;
    chk("bp_resume_ack", 32'(bus.AckOut), 32'b0010);
    cyc();
    chk("bp_resume_burst", 32'(dut.burst_q), 32'd2);

    // Enable gating mid-burst
    reset_dut();
    clk_en = 1'b1; bus.ReqIn = 4'b0001; bus.FifoACK = 1'b1;
    cyc();
    cyc();
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("en_freq%0d", c), 32'(bus.FifoREQ), 32'd0);
      chk($sformatf("en_ack%0d", c), 32'(bus.AckOut), 32'd0);
      chk($sformatf("en_busy%0d", c), 32'(bus.Busy), 32'd1);
      chk($sformatf("en_gid%0d", c), 32'(bus.GrantID), 32'd0);
      cyc();
      chk($sformatf("en_burst%0d", c), 32'(dut.burst_q), 32'd1);
    end
    clk_en = 1'b1;
    #2;
    chk("en_resume_ack", 32'(bus.AckOut), 32'b0001);
    cyc();
    chk("en_resume_burst", 32'(dut.burst_q), 32'd2);

    // Withdrawal of port 0 after two words, port 3 waiting
    reset_dut();
    clk_en = 1'b1; bus.ReqIn = 4'b1001; bus.FifoACK = 1'b1;
    cyc();
    #2;
    chk("wd_gid0", 32'(bus.GrantID), 32'd0);
    cyc();
    cyc();
    bus.ReqIn = 4'b1000;
    #2;
    chk("wd_freq", 32'(bus.FifoREQ), 32'd0);
    chk("wd_burst_pre", 32'(dut.burst_q), 32'd2);
    cyc();
    #2;
    chk("wd_idle_busy", 32'(bus.Busy), 32'd0);
    chk("wd_ptr", 32'(dut.ptr_q), 32'd1);
    chk("wd_burst_post", 32'(dut.burst_q), 32'd2);
    cyc();
    #2;
    chk("wd_next_gid", 32'(bus.GrantID), 32'd3);
    chk("wd_next_ack", 32'(bus.AckOut), 32'b1000);

    // Reset with clk_en low while granted to port 3 (pointer at 1)
    sync_rst = 1'b1; clk_en = 1'b0;
    cyc();
    #2;
    chk("mr_busy", 32'(bus.Busy), 32'd0);
    chk("mr_ack",  32'(bus.AckOut), 32'd0);
    chk("mr_freq", 32'(bus.FifoREQ), 32'd0);
    chk("mr_data", 32'(bus.FifoData), 32'd0);
    chk("mr_gid",  32'(bus.GrantID), 32'd0);
    chk("mr_ptr",  32'(dut.ptr_q), 32'd0);
    sync_rst = 1'b0; clk_en = 1'b1; bus.ReqIn = 4'b1001;
    cyc();
    #2;
    chk("mr_rearb_gid", 32'(bus.GrantID), 32'd0);
    chk("mr_rearb_busy", 32'(bus.Busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_input_arbiter.md
# fifo_input_arbiter

Round-robin arbiter that shares the single REQ/ACK input port of one `BufferedFIFO` between `PORTCOUNT` producers. It holds a grant per producer for a bounded burst, then rotates priority, so no producer is starved. It sits directly in front of the FIFO input. Its `Fifo*` ports connect to the FIFO's `InputREQ`/`InputACK`/`InputData`.

## Interface

Parameters:
- `DATABITWIDTH`, 16, width of one data word.
- `PORTCOUNT`, 4, number of producers; must be ≥ 2. `IDBITWIDTH` = $clog2(PORTCOUNT).
- `BURSTLIMIT`, 4, maximum words per grant; must be ≥ 1. The burst counter is $clog2(BURSTLIMIT+1) bits.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `clk_en`  in  1  global enable; state advances only when high.
- `sync_rst`  in  1  synchronous, active-high reset; overrides `clk_en`.
- `ReqIn`  in  PORTCOUNT  per-producer request; bit i means `DataIn` slice i is valid.
- `AckOut`  out  PORTCOUNT  per-producer acknowledge; a transfer occurs on a cycle with `ReqIn[i]` and `AckOut[i]` both high.
- `DataIn`  in  PORTCOUNT*DATABITWIDTH  producer i occupies bits [i*DATABITWIDTH +: DATABITWIDTH].
- `FifoREQ`  out  1  to FIFO `InputREQ`.
- `FifoACK`  in  1  from FIFO `InputACK` (FIFO can accept).
- `FifoData`  out  DATABITWIDTH  to FIFO `InputData`.
- `GrantID`  out  IDBITWIDTH  currently granted producer.
- `Busy`  out  1  high while in GRANTED.

## Operation

- Registered state:
  - `State` ∈ {IDLE, GRANTED}
  - `Pointer` (IDBITWIDTH), the highest-priority port
  - `GrantID` (IDBITWIDTH)
  - `BurstCount`
- Reset on any edge with `sync_rst` = 1, regardless of `clk_en`: State=IDLE, Pointer=0, GrantID=0, BurstCount=0.
- Output values after reset: FifoREQ=0, AckOut=0, FifoData=0, GrantID=0, Busy=0.
- IDLE:
  - All outputs are zero except `GrantID`, which holds its last value.
  - If `clk_en` is high and `ReqIn` != 0: the winner is the first set bit searching Pointer, Pointer+1, … with modulo-PORTCOUNT wrap.
  - On the winner: GrantID←winner, BurstCount←0, State←GRANTED.
- GRANTED, with g = GrantID:
  - FifoREQ = clk_en & ReqIn[g].
  - FifoData = DataIn slice g.
  - AckOut[g] = clk_en & FifoACK; all other AckOut bits are 0.
  - Busy=1.
  - Transfer when clk_en & ReqIn[g] & FifoACK; on a transfer, BurstCount increments.
- Release from GRANTED to IDLE, with Pointer←(g+1) mod PORTCOUNT, when either:
  - a transfer occurs and BurstCount+1 == BURSTLIMIT, or
  - clk_en is high and ReqIn[g] is 0, i.e. the producer withdrew; no transfer happens that cycle.
- FIFO full (FifoACK=0) while ReqIn[g]=1: the grant is held, BurstCount is unchanged, and there is no timeout.
- Requests from non-granted ports are ignored until the next arbitration. Those producers must hold REQ and data stable.
- A producer must not change `DataIn` while its REQ is high and un-acknowledged.

## Timing

- Arbitration latency: a request seen in IDLE on edge N gives GrantID/Busy valid after N. The first possible transfer is in cycle N+1.
- Within a grant, one word transfers per cycle while ReqIn[g] and FifoACK are both high.
- Exactly one IDLE bubble cycle follows every release.
- Sustained throughput with all ports requesting: BURSTLIMIT words per BURSTLIMIT+1 cycles.
- AckOut and FifoREQ are combinational from state, ReqIn, FifoACK and clk_en. There are no combinational paths from DataIn to control.
- clk_en low: all state is frozen, and FifoREQ and AckOut are forced to 0, so no handshake completes.

## Test plan

- Single producer: port 2 requests 3 words, FifoACK=1, others idle.
  - Expect GrantID=2 one cycle after REQ rises.
  - Expect AckOut=4'b0100 for 3 consecutive cycles, and FifoData equal to the 3 words in order.
  - Expect Pointer=3 after release.
- Full contention: all four ports request continuously, BURSTLIMIT=4, FifoACK=1.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly 4 words per grant and one Busy=0 cycle between grants.
- Backpressure: during a grant to port 1, hold FifoACK=0 for 5 cycles, with a downstream `BufferedFIFO` of depth 4 filled and not drained.
  - Expect FifoREQ=1, AckOut=0, GrantID=1, and BurstCount unchanged throughout.
  - Expect transfers to resume when FifoACK returns to 1.
- Withdrawal: port 0 drops ReqIn after 2 words, with port 3 also requesting.
  - Expect release with no extra transfer, Pointer=1, and port 3 granted next (wrap search 1,2,3).
- Enable gating: drop clk_en for 3 cycles mid-burst.
  - Expect AckOut=0 and FifoREQ=0, with no change to State, GrantID or BurstCount.
  - Expect the burst to continue once clk_en returns.
- Reset mid-operation: assert sync_rst with clk_en=0 while GRANTED.
  - Expect State=IDLE, Pointer=0, all outputs 0 on the next cycle.
  - Expect re-arbitration to start from port 0.
